// File: rtl/tetris_gfx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tetris_gfx_pkg
// Purpose  : Shared screen geometry and frame-write arbiter state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package tetris_gfx_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int COORD_W  = 11;

    // Arbiter FSM encoding
    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_START = 2'd1;
    localparam logic [1:0] ARB_CLEAR = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin arbiter with a last-grant pointer.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // 1 means requester 1 was granted most recently, so requester 0 wins ties
    logic last_q;
    logic last_d;

    // Grant a lone requester directly; on a tie grant the one not served last
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                grant = last_q ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
        last_d = last_q;
        if (grant[1]) begin
            last_d = 1'b1;
        end else if (grant[0]) begin
            last_d = 1'b0;
        end
    end

    // Last-grant pointer register
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/frame_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : frame_write_arbiter
// Purpose  : Shares the frame-buffer write port between the clear sweep and
//            two round-robin draw requesters.
// Revision : 1.0 - initial release
// ============================================================================
module frame_write_arbiter
    import tetris_gfx_pkg::*;
#(
    parameter int                 COLOR_W  = 3,
    parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_req,
    output logic               clear_rst,
    input  logic [10:0]        clear_x,
    input  logic [10:0]        clear_y,
    input  logic               clear_done,
    input  logic [1:0]         draw_req,
    input  logic [10:0]        draw_x0,
    input  logic [10:0]        draw_y0,
    input  logic [10:0]        draw_x1,
    input  logic [10:0]        draw_y1,
    input  logic [COLOR_W-1:0] draw_color0,
    input  logic [COLOR_W-1:0] draw_color1,
    output logic [1:0]         draw_grant,
    output logic               wr_en,
    output logic [10:0]        wr_x,
    output logic [10:0]        wr_y,
    output logic [COLOR_W-1:0] wr_color,
    output logic               busy
);

    logic [1:0]         state_q, state_d;
    logic               clear_pending_q, clear_pending_d;
    logic               wr_en_q, wr_en_d;
    logic [10:0]        wr_x_q, wr_x_d;
    logic [10:0]        wr_y_q, wr_y_d;
    logic [COLOR_W-1:0] wr_color_q, wr_color_d;
    logic               arb_en;
    logic               sweep_in_range;

    // Draws are only served when no clear is starting or queued
    assign arb_en = (state_q == ARB_IDLE) && !clear_req && !clear_pending_q && !reset;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .req   (draw_req),
        .grant (draw_grant)
    );

    assign clear_rst      = reset || (state_q == ARB_START);
    assign busy           = (state_q == ARB_START) || (state_q == ARB_CLEAR);
    assign sweep_in_range = (clear_x < COORD_W'(H_ACTIVE)) && (clear_y < COORD_W'(V_ACTIVE));

    // Clear sequencing; a request during a clear queues exactly one more
    always_comb begin
        state_d         = state_q;
        clear_pending_d = clear_pending_q;
        case (state_q)
            ARB_IDLE: begin
                if (clear_req || clear_pending_q) begin
                    state_d         = ARB_START;
                    clear_pending_d = 1'b0;
                end
            end
            ARB_START: begin
                state_d = ARB_CLEAR;
                if (clear_req) clear_pending_d = 1'b1;
            end
            ARB_CLEAR: begin
                if (clear_done) state_d = ARB_IDLE;
                if (clear_req) clear_pending_d = 1'b1;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Next write: granted draw in IDLE, in-range sweep point in CLEAR
    always_comb begin
        wr_en_d    = 1'b0;
        wr_x_d     = wr_x_q;
        wr_y_d     = wr_y_q;
        wr_color_d = wr_color_q;
        if (state_q == ARB_IDLE) begin
            if (draw_grant[0]) begin
                wr_en_d    = 1'b1;
                wr_x_d     = draw_x0;
                wr_y_d     = draw_y0;
                wr_color_d = draw_color0;
            end else if (draw_grant[1]) begin
                wr_en_d    = 1'b1;
                wr_x_d     = draw_x1;
                wr_y_d     = draw_y1;
                wr_color_d = draw_color1;
            end
        end else if (state_q == ARB_CLEAR) begin
            wr_en_d    = sweep_in_range;
            wr_x_d     = clear_x;
            wr_y_d     = clear_y;
            wr_color_d = BG_COLOR;
        end
    end

    // State and write-port registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ARB_IDLE;
            clear_pending_q <= 1'b0;
            wr_en_q         <= 1'b0;
            wr_x_q          <= '0;
            wr_y_q          <= '0;
            wr_color_q      <= '0;
        end else begin
            state_q         <= state_d;
            clear_pending_q <= clear_pending_d;
            wr_en_q         <= wr_en_d;
            wr_x_q          <= wr_x_d;
            wr_y_q          <= wr_y_d;
            wr_color_q      <= wr_color_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_x     = wr_x_q;
    assign wr_y     = wr_y_q;
    assign wr_color = wr_color_q;

endmodule
`default_nettype wire

// File: doc/frame_write_arbiter.md
# frame_write_arbiter

Owns the single frame-buffer write port and shares it between the full-screen clear sweep generator and two drawing requesters (0 = falling-piece renderer, 1 = board/score renderer). It sequences the clear generator by pulsing its reset, then forwards the sweep coordinates as background-colour writes. When no clear is in progress, it round-robin arbitrates the two draw requesters. All frame-buffer writes are registered, one per cycle maximum.

## Interface
Parameters:
- COLOR_W, 3 — pixel colour width
- BG_COLOR, 3'b000 — colour written by a clear

Ports:
- clk  in  1  — system clock
- reset  in  1  — synchronous, active-high
- clear_req  in  1  — one-cycle pulse requesting a full-screen clear
- clear_rst  out  1  — reset to the sweep generator; combinational, high when reset=1 or state=START
- clear_x, clear_y  in  11  — sweep generator coordinates
- clear_done  in  1  — sweep generator terminal flag (x=640, y=480)
- draw_req  in  2  — per-requester write request, held until granted
- draw_x0, draw_y0, draw_x1, draw_y1  in  11  — requester coordinates
- draw_color0, draw_color1  in  COLOR_W  — requester colours
- draw_grant  out  2  — combinational one-hot grant; request consumed in the cycle where req&grant
- wr_en  out  1  — registered frame-buffer write strobe
- wr_x, wr_y  out  11  — registered write address
- wr_color  out  COLOR_W  — registered write data
- busy  out  1  — high in START or CLEAR

## Operation
- FSM states:
  - IDLE→START: on clear_req or clear_pending.
  - START→CLEAR: unconditional, one cycle.
  - CLEAR→IDLE: on clear_done.
- IDLE:
  - Round-robin arbitration between draw_req[0] and draw_req[1].
  - Single requester is granted.
  - If both request, grant the one not granted last.
  - The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - A granted request produces a write next cycle with that requester's x, y, colour.
- START:
  - clear_rst=1; draw_grant=0; wr_en=0.
- CLEAR:
  - draw_grant=0.
  - Each cycle, clear_x/clear_y are sampled; a write is issued next cycle with BG_COLOR only if clear_x<640 and clear_y<480.
  - Out-of-range sweep points (x=640 or y=480) produce wr_en=0.
- clear_req arriving in IDLE together with draw_req:
  - Clear wins; draw_grant=0 in that cycle.
- clear_req arriving in START or CLEAR:
  - Sets clear_pending; exactly one further clear follows.
  - Multiple such pulses still yield only one further clear.
  - clear_pending clears on entry to START.
- clear_done seen in IDLE is ignored.
- Draw coordinates are not range-checked; the frame buffer owns that.

## Timing
- Reset values:
  - state=IDLE, clear_pending=0, last-grant=1.
  - wr_en=0, wr_x=0, wr_y=0, wr_color=0.
  - draw_grant=0, busy=0.
- Latency: grant cycle → wr_en one cycle later.
- A clear occupies 1 START cycle, then 641×481 = 308,321 CLEAR cycles, producing exactly 307,200 writes.
- busy drops the cycle after clear_done is sampled.
- The first draw grant may occur in that same cycle.
- Reset mid-clear:
  - Returns to IDLE next edge; wr_en=0; pending is dropped.
  - The generator is re-reset via clear_rst.

## Structure
- Package tetris_gfx_pkg holds:
  - H_ACTIVE=640, V_ACTIVE=480, COORD_W=11.
  - The arbiter state enum (IDLE, START, CLEAR).
- Sub-module rr_arb2: 2-way round-robin grant with a last-grant flop. The enable input is tied to (state==IDLE && !clear_req && !clear_pending).
- The bench instantiates the existing clear sweep generator driven by clear_rst.

## Test plan
- Reset, then hold draw_req=2'b11 for 4 cycles → grants 01,10,01,10; wr_x/wr_y follow one cycle later.
- Only draw_req[1]=1 for 3 cycles → draw_grant=10 every cycle, three writes with draw_color1.
- clear_req pulse with draw_req=11 → draw_grant=0 immediately; START 1 cycle; 307,200 writes with BG_COLOR; last write at (639,479); busy low after clear_done.
- clear_req twice during CLEAR → exactly one more full clear (total 614,400 BG writes), then IDLE.
- reset asserted at cycle 1000 of a clear → IDLE, wr_en=0, no pending clear, draw grants resume after reset release.
